// File: rtl/wb_hp_pkg.sv
// rtl/wb_hp_pkg.sv - shared widths and state encoding for the Wishbone initiator
package wb_hp_pkg;
   localparam int WB_ADR_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/wb_hp_initiator_if.sv
// rtl/wb_hp_initiator_if.sv - command, response and Wishbone master signal bundle
interface wb_hp_initiator_if;
   import wb_hp_pkg::*;

   logic                cmd_valid_i;
   logic                cmd_ready_o;
   logic                cmd_we_i;
   logic [WB_ADR_W-1:0] cmd_adr_i;
   logic [31:0]         cmd_dat_i;
   logic [WB_SEL_W-1:0] cmd_sel_i;

   logic                rsp_valid_o;
   logic                rsp_ready_i;
   logic [31:0]         rsp_dat_o;
   logic                rsp_err_o;

   logic                wbm_cyc_o;
   logic                wbm_stb_o;
   logic                wbm_we_o;
   logic [WB_ADR_W-1:0] wbm_adr_o;
   logic [31:0]         wbm_dat_o;
   logic [WB_SEL_W-1:0] wbm_sel_o;
   logic                wbm_ack_i;
   logic                wbm_err_i;
   logic [31:0]         wbm_dat_i;

   logic [7:0]          err_count_o;

   modport master (
      input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      input  rsp_ready_i, wbm_ack_i, wbm_err_i, wbm_dat_i,
      output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      output err_count_o
   );

   modport slave (
      output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
      output rsp_ready_i, wbm_ack_i, wbm_err_i, wbm_dat_i,
      input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      input  err_count_o
   );
endinterface

// File: rtl/wb_hp_timeout.sv
// rtl/wb_hp_timeout.sv - bus wait counter, expires on the TIMEOUT-th BUS cycle
module wb_hp_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= 8'd0;
      else if (clear)
         count <= 8'd0;
      else if (enable)
         count <= count + 8'd1;
   end

   assign expire = (count == 8'(TIMEOUT - 1));
endmodule

// File: rtl/wb_hp_initiator.sv
// rtl/wb_hp_initiator.sv - single-outstanding Wishbone master with timeout and error count
module wb_hp_initiator
   import wb_hp_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   wb_hp_initiator_if.master    bus
);
   state_t              state;
   state_t              state_nx;
   logic                accept;
   logic                in_bus;
   logic                done;
   logic                fail;
   logic                expire;
   logic                wait_clear;
   logic                wait_en;
   logic                we_q;
   logic [WB_ADR_W-1:0] adr_q;
   logic [31:0]         dat_q;
   logic [WB_SEL_W-1:0] sel_q;
   logic [31:0]         rsp_dat_q;
   logic                rsp_err_q;
   logic [7:0]          err_cnt_q;

   assign in_bus     = (state == BUS);
   assign accept     = (state == IDLE) && bus.cmd_valid_i;
   assign done       = in_bus && (bus.wbm_ack_i || bus.wbm_err_i || expire);
   // err beats ack; a late ack in the expiring cycle still completes cleanly
   assign fail       = in_bus && (bus.wbm_err_i || (!bus.wbm_ack_i && expire));
   assign wait_clear = !in_bus;
   assign wait_en    = in_bus && !bus.wbm_ack_i && !bus.wbm_err_i;

   wb_hp_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clear  (wait_clear),
      .enable (wait_en),
      .expire (expire)
   );

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = BUS;
         BUS:     if (done) state_nx = RESP;
         RESP:    if (bus.rsp_ready_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_ready_o = (state == IDLE) && !wb_rst_i;
      bus.wbm_cyc_o   = in_bus;
      bus.wbm_stb_o   = in_bus;
      bus.wbm_we_o    = we_q;
      bus.wbm_adr_o   = adr_q;
      bus.wbm_dat_o   = dat_q;
      bus.wbm_sel_o   = sel_q;
      bus.rsp_valid_o = (state == RESP);
      bus.rsp_dat_o   = rsp_dat_q;
      bus.rsp_err_o   = rsp_err_q;
      bus.err_count_o = err_cnt_q;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         sel_q     <= '0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         if (accept) begin
            we_q  <= bus.cmd_we_i;
            adr_q <= bus.cmd_adr_i;
            dat_q <= bus.cmd_we_i ? bus.cmd_dat_i : 32'd0;
            sel_q <= bus.cmd_sel_i;
         end
         if (done) begin
            rsp_err_q <= fail;
            rsp_dat_q <= (fail || we_q) ? 32'd0 : bus.wbm_dat_i;
            if (fail && err_cnt_q != 8'hFF)
               err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_wb_hp_initiator.sv
// tb/tb_wb_hp_initiator.sv - scoreboard bench for wb_hp_initiator
`timescale 1ns/1ps
module tb_wb_hp_initiator;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_hp_initiator_if bus();

   wb_hp_initiator #(.TIMEOUT(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   int          n_chk = 0;
   int          n_pass = 0;
   int          exp_errs = 0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   // Monitor: pops an expected response at every completed response handshake
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
         if (exp_q.size() == 0) begin
            chk1("unexpected_rsp", bus.rsp_valid_o, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk32("rsp_dat", bus.rsp_dat_o, mon_e[31:0]);
            chk1("rsp_err", bus.rsp_err_o, mon_e[32]);
         end
      end
   end

   // mode: 0 ack, 1 err, 2 ack+err, 3 silent slave
   task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int waits, input int mode,
                      input logic [31:0] rdat, input int hold);
      int   ncyc;
      logic e;
      e = (mode != 0);
      exp_q.push_back({e, (e || we) ? 32'h0 : rdat});
      if (e && exp_errs < 255) exp_errs++;
      @(negedge clk);
      chk1("cmd_ready_idle", bus.cmd_ready_o, 1'b1);
      bus.cmd_we_i    = we;
      bus.cmd_adr_i   = adr;
      bus.cmd_dat_i   = dat;
      bus.cmd_sel_i   = sel;
      bus.cmd_valid_i = 1'b1;
      bus.rsp_ready_i = (hold == 0);
      @(posedge clk);
      #1 bus.cmd_valid_i = 1'b0;
      bus.cmd_adr_i = 32'hFFFF_FFFF;
      bus.cmd_dat_i = 32'hFFFF_FFFF;
      ncyc = 0;
      @(negedge clk);
      while (bus.wbm_cyc_o && ncyc < 300) begin
         chk1("stb", bus.wbm_stb_o, 1'b1);
         chk1("we", bus.wbm_we_o, we);
         chk32("adr", bus.wbm_adr_o, adr);
         chk32("wdat", bus.wbm_dat_o, we ? dat : 32'h0);
         chk32("sel", {28'h0, bus.wbm_sel_o}, {28'h0, sel});
         chk1("cmd_ready_bus", bus.cmd_ready_o, 1'b0);
         if (mode != 3 && ncyc == waits) begin
            bus.wbm_ack_i = (mode == 0 || mode == 2);
            bus.wbm_err_i = (mode == 1 || mode == 2);
            bus.wbm_dat_i = rdat;
         end
         @(posedge clk);
         #1;
         bus.wbm_ack_i = 1'b0;
         bus.wbm_err_i = 1'b0;
         bus.wbm_dat_i = 32'hA5A5_A5A5;
         ncyc++;
         @(negedge clk);
      end
      chk32("bus_cycles", 32'(ncyc), (mode == 3) ? 32'(TO) : 32'(waits + 1));
      chk1("stb_drop", bus.wbm_stb_o, 1'b0);
      chk1("rsp_valid_latency", bus.rsp_valid_o, 1'b1);
      chk32("err_count", {24'h0, bus.err_count_o}, 32'(exp_errs));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            chk1("hold_valid", bus.rsp_valid_o, 1'b1);
            chk1("hold_err", bus.rsp_err_o, e);
            chk32("hold_dat", bus.rsp_dat_o, (e || we) ? 32'h0 : rdat);
            chk1("hold_cmd_ready", bus.cmd_ready_o, 1'b0);
            @(negedge clk);
         end
         @(posedge clk);
         #1 bus.rsp_ready_i = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1 chk1("rsp_valid_drop", bus.rsp_valid_o, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.cmd_valid_i = 1'b1;
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'h0;
      bus.cmd_dat_i   = 32'h0;
      bus.cmd_sel_i   = 4'h0;
      bus.rsp_ready_i = 1'b1;
      bus.wbm_ack_i   = 1'b0;
      bus.wbm_err_i   = 1'b0;
      bus.wbm_dat_i   = 32'h0;

      // Held in reset with a command offered: nothing may be accepted
      repeat (3) @(negedge clk);
      chk1("rst_cmd_ready", bus.cmd_ready_o, 1'b0);
      chk1("rst_cyc", bus.wbm_cyc_o, 1'b0);
      chk1("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk32("rst_err_count", {24'h0, bus.err_count_o}, 32'h0);
      chk32("rst_adr", bus.wbm_adr_o, 32'h0);
      bus.cmd_valid_i = 1'b0;
      rst = 1'b0;

      txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 0, 32'h0, 0);
      txn(1'b0, 32'h3000_0000, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 0);
      txn(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 3, 32'h0, 0);
      txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1, 2, 32'hCAFE_F00D, 5);
      txn(1'b0, 32'h3000_0010, 32'h0, 4'hC, 3, 0, 32'h0BAD_F00D, 0);
      txn(1'b1, 32'h3000_0014, 32'h5555_AAAA, 4'h1, 0, 1, 32'h0, 0);

      // Stray ack/err while idle must have no effect
      @(negedge clk);
      bus.wbm_ack_i = 1'b1;
      bus.wbm_err_i = 1'b1;
      @(posedge clk);
      #1 bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      @(negedge clk);
      chk1("idle_ack_rsp_valid", bus.rsp_valid_o, 1'b0);
      chk1("idle_ack_cyc", bus.wbm_cyc_o, 1'b0);
      chk32("idle_ack_err_count", {24'h0, bus.err_count_o}, 32'(exp_errs));

      // Reset pulsed mid-BUS abandons the transaction
      bus.cmd_we_i    = 1'b0;
      bus.cmd_adr_i   = 32'h3000_0020;
      bus.cmd_sel_i   = 4'hF;
      bus.cmd_valid_i = 1'b1;
      @(posedge clk);
      #1 bus.cmd_valid_i = 1'b0;
      @(negedge clk);
      chk1("midbus_cyc_before", bus.wbm_cyc_o, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("midbus_rst_cyc", bus.wbm_cyc_o, 1'b0);
      chk1("midbus_rst_stb", bus.wbm_stb_o, 1'b0);
      chk32("midbus_rst_adr", bus.wbm_adr_o, 32'h0);
      chk32("midbus_rst_err_count", {24'h0, bus.err_count_o}, 32'h0);
      chk1("midbus_rst_cmd_ready", bus.cmd_ready_o, 1'b0);
      exp_errs = 0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("post_rst_rsp_valid", bus.rsp_valid_o, 1'b0);
         chk1("post_rst_cyc", bus.wbm_cyc_o, 1'b0);
      end

      // Error counter saturates at 255
      for (int i = 0; i < 300; i++)
         txn(i[0], 32'h4000_0000 + 32'(i), 32'(i), 4'hF, 0, 1, 32'h0, 0);
      chk32("err_count_sat", {24'h0, bus.err_count_o}, 32'd255);

      @(negedge clk);
      chk32("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/wb_hp_initiator.md
WB_HP_INITIATOR -- requirements
Module: wb_hp_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: bus cycles waited for ack/err before abort (legal 2..255).
REQ-002 SHALL have port wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid_i  in  1  command offered.
REQ-005 SHALL have port cmd_ready_o  out  1  command accepted when valid&ready.
REQ-006 SHALL have ports cmd_we_i in 1, cmd_adr_i in 32, cmd_dat_i in 32, cmd_sel_i in 4: write flag, address, write data, byte select.
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-008 SHALL have ports rsp_dat_o out 32 (read data), rsp_err_o out 1 (bus error or timeout).
REQ-009 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_adr_o out 32; wbm_dat_o out 32; wbm_sel_o out 4.
REQ-010 SHALL have ports wbm_ack_i in 1, wbm_err_i in 1, wbm_dat_i in 32: slave response.
REQ-011 SHALL have port err_count_o  out  8  saturating count of errored/timed-out cycles.

Function
REQ-012 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; one transaction outstanding max.
REQ-013 IDLE: cmd_ready_o=1 (0 while wb_rst_i high); on valid&ready latch we/adr/dat/sel, go BUS.
REQ-014 BUS: wbm_cyc_o=wbm_stb_o=1 from the cycle after acceptance; adr/dat/sel/we held stable throughout; wbm_dat_o=0 for reads.
REQ-015 BUS: ack sampled high -> latch wbm_dat_i (reads) or 0 (writes) into rsp_dat_o, rsp_err_o=0, go RESP; cyc/stb low next cycle.
REQ-016 BUS: err sampled high -> rsp_dat_o=0, rsp_err_o=1, go RESP; ack and err in same cycle -> err wins.
REQ-017 BUS: 8-bit wait counter cleared on entry, increments each BUS cycle without ack/err; reaching TIMEOUT-1 -> abort as err (REQ-016), cyc/stb dropped.
REQ-018 RESP: rsp_valid_o=1, rsp_dat_o/rsp_err_o stable until rsp_ready_i sampled high, then IDLE; cmd_ready_o=0 in BUS/RESP.
REQ-019 Latency: accept in cycle N, zero-wait ack in N+1 -> rsp_valid_o in N+2; back-to-back commands minimum 3 cycles apart.
REQ-020 err_count_o SHALL increment on each RESP entry with rsp_err_o=1, saturating at 255, no wrap.
REQ-021 ack/err sampled outside BUS SHALL be ignored.

Reset
REQ-022 wb_rst_i assertion SHALL immediately (asynchronously) force IDLE, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o/wbm_dat_o/wbm_sel_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_err_o=0, err_count_o=0, wait counter 0.
REQ-023 Reset mid-BUS or mid-RESP SHALL abandon the transaction with no response emitted after release.
REQ-024 First command accepted no earlier than first rising edge after wb_rst_i deasserts.

Structure
REQ-025 State enum (IDLE/BUS/RESP) and WB_ADR_W=32, WB_SEL_W=4 SHALL live in shared package wb_hp_pkg.
REQ-026 Wait counter SHALL be sub-module wb_hp_timeout (clear, enable, expire out, TIMEOUT param); all else in one module.

Verification
REQ-027 Write adr=0x3000_0004 dat=0xDEAD_BEEF sel=0xF, ack after 2 waits -> cyc/stb high 3 cycles, rsp_err_o=0, rsp_dat_o=0.
REQ-028 Read adr=0x3000_0000, zero-wait ack with wbm_dat_i=0x1234_5678 -> rsp_valid_o at accept+2, rsp_dat_o=0x1234_5678.
REQ-029 Read, slave silent, TIMEOUT=64 -> cyc drops after 64 BUS cycles, rsp_err_o=1, err_count_o 0->1.
REQ-030 ack and err same cycle -> rsp_err_o=1; rsp_ready_i held low 5 cycles -> rsp_valid_o/data stable, cmd_ready_o=0.
REQ-031 wb_rst_i pulsed mid-BUS -> cyc/stb low same cycle, no rsp_valid_o after release; 300 errors -> err_count_o=255.
